// File: rtl/coin_pkg.sv
// Shared types for the coin acceptor: coin encoding, coin values and the
// release FSM state encoding.
package coin_pkg;

  typedef enum logic {
    COIN_NICKEL = 1'b0,
    COIN_DIME   = 1'b1
  } coin_t;

  localparam int NICKEL_CENTS = 5;
  localparam int DIME_CENTS   = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2
  } rel_state_t;

endpackage

// File: rtl/coin_debounce.sv
// One sensor channel: 2-flop synchroniser, debounce counter and a one-cycle
// event on each rising edge of the filtered level.
module coin_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_raw,
  output logic o_event
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST_COUNT = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic          r_level_d;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_sync1   <= i_raw;
      r_sync2   <= r_sync1;
      r_level_d <= r_level;
      // The edge that would bring the count to DEBOUNCE_CYCLES flips the level instead.
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == LAST_COUNT) begin
        r_level <= ~r_level;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_event = r_level & ~r_level_d;

endmodule

// File: rtl/coin_acceptor.sv
// Vending machine coin front end: debounced nickel/dime sensors feed a small
// FIFO that a release FSM drains as one-cycle pulses separated by an idle gap.
module coin_acceptor
  import coin_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int QUEUE_DEPTH     = 4,
  parameter int GAP_CYCLES      = 1
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               nickel_raw,
  input  logic                               dime_raw,
  input  logic                               enable,
  output logic                               nickel_in,
  output logic                               dime_in,
  output logic                               coin_return,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0]   queue_count,
  output rel_state_t                         o_dbg_state
);

  localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);
  localparam int AW    = $clog2(QUEUE_DEPTH);
  localparam int GW    = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES + 1);
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(QUEUE_DEPTH);
  localparam logic [GW-1:0]    GAP_LOAD   = GW'(GAP_CYCLES);

  logic w_ev_nickel;
  logic w_ev_dime;

  coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_nickel_db (
    .i_clock (clock),
    .i_reset (reset),
    .i_raw   (nickel_raw),
    .o_event (w_ev_nickel)
  );

  coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dime_db (
    .i_clock (clock),
    .i_reset (reset),
    .i_raw   (dime_raw),
    .o_event (w_ev_dime)
  );

  // ---------------- pending-coin FIFO ----------------
  coin_t            r_mem [QUEUE_DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic  w_empty;
  logic  w_full;
  logic  w_push_req;
  logic  w_push;
  logic  w_pop;
  logic  w_reject;
  coin_t w_push_type;
  coin_t w_head;

  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == FULL_COUNT);
  assign w_push_req  = w_ev_nickel ^ w_ev_dime;
  assign w_push      = w_push_req & (~w_full | w_pop);
  // Simultaneous events are a jam: neither coin is trusted.
  assign w_reject    = (w_ev_nickel & w_ev_dime) | (w_push_req & w_full & ~w_pop);
  assign w_push_type = w_ev_dime ? COIN_DIME : COIN_NICKEL;
  assign w_head      = r_mem[r_rd_ptr];

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_push_type;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // ---------------- release FSM ----------------
  rel_state_t    r_state;
  rel_state_t    w_state_nxt;
  logic [GW-1:0] r_gap_cnt;
  logic [GW-1:0] w_gap_nxt;
  logic          r_nickel_in;
  logic          r_dime_in;
  logic          r_coin_return;
  logic          w_nickel_nxt;
  logic          w_dime_nxt;
  logic          w_return_nxt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_gap_cnt     <= '0;
      r_nickel_in   <= 1'b0;
      r_dime_in     <= 1'b0;
      r_coin_return <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_gap_cnt     <= w_gap_nxt;
      r_nickel_in   <= w_nickel_nxt;
      r_dime_in     <= w_dime_nxt;
      r_coin_return <= w_return_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_gap_nxt   = r_gap_cnt;
    w_pop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (enable && !w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_PULSE;
        end
      end
      ST_PULSE: begin
        if (GAP_CYCLES == 0) begin
          if (enable && !w_empty) begin
            w_pop       = 1'b1;
            w_state_nxt = ST_PULSE;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_state_nxt = ST_GAP;
          w_gap_nxt   = GAP_LOAD;
        end
      end
      ST_GAP: begin
        if (r_gap_cnt == GW'(1)) begin
          if (enable && !w_empty) begin
            w_pop       = 1'b1;
            w_state_nxt = ST_PULSE;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_gap_nxt = r_gap_cnt - 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // A pop is the only way into PULSE, so the popped type selects the pulse line.
  always_comb begin
    w_nickel_nxt = w_pop & (w_head == COIN_NICKEL);
    w_dime_nxt   = w_pop & (w_head == COIN_DIME);
    w_return_nxt = w_reject;
  end

  assign nickel_in   = r_nickel_in;
  assign dime_in     = r_dime_in;
  assign coin_return = r_coin_return;
  assign queue_count = r_count;
  assign o_dbg_state = r_state;

endmodule
